// File: rtl/mips_pkg.sv
// Shared definitions for the memory dump reader: default word width and FSM states.
// MEM_DUMP_CHECKSUM_EN adds the CSUM state used for the trailing checksum beat.
package mips_pkg;

  localparam int DATA_W_DEF = 32;

`ifdef MEM_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, CSUM, FIN} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, FIN} state_t;
`endif

endpackage

// File: rtl/mem_dump_reader.sv
// Streams count words from a synchronous-read data memory starting at base_addr.
// MEM_DUMP_CHECKSUM_EN appends a wrapping-sum beat after the data beats.
module mem_dump_reader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  state_t            state_reg;
  logic [ADDR_W:0]   remaining_reg;
  logic              final_word;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum_reg;
`endif

  assign final_word = (remaining_reg == (ADDR_W+1)'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_re        <= 1'b0;
      mem_addr      <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
      sum_reg       <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            busy          <= 1'b1;
            mem_addr      <= base_addr;
            remaining_reg <= count;
`ifdef MEM_DUMP_CHECKSUM_EN
            sum_reg       <= '0;
`endif
            if (count != '0) begin
              state_reg <= READ;
              mem_re    <= 1'b1;
            end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
              // Empty dump still produces a single zero checksum beat.
              state_reg <= CSUM;
              out_valid <= 1'b1;
              out_data  <= '0;
              out_last  <= 1'b1;
`else
              state_reg <= FIN;
`endif
            end
          end
        end
        READ: begin
          mem_re    <= 1'b0;
          state_reg <= WAIT;
        end
        WAIT: begin
          out_data  <= mem_rdata;
          out_valid <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
          out_last  <= 1'b0;
`else
          out_last  <= final_word;
`endif
          state_reg <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            remaining_reg <= remaining_reg - (ADDR_W+1)'(1);
            mem_addr      <= mem_addr + ADDR_W'(1);
`ifdef MEM_DUMP_CHECKSUM_EN
            sum_reg       <= sum_reg + out_data;
`endif
            if (!final_word) begin
              state_reg <= READ;
              mem_re    <= 1'b1;
            end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
              // Fold the word being accepted now into the emitted sum.
              state_reg <= CSUM;
              out_valid <= 1'b1;
              out_data  <= sum_reg + out_data;
              out_last  <= 1'b1;
`else
              state_reg <= FIN;
`endif
            end
          end
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        CSUM: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state_reg <= FIN;
          end
        end
`endif
        FIN: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_dump_reader.md
MEM_DUMP_READER -- requirements
Module: mem_dump_reader

Interface
REQ-001 Parameter ADDR_W, default 8, data-memory word-address width.
REQ-002 Parameter DATA_W, default 32, data-memory word width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to begin a dump; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_W  first word address; captured on accepted start.
REQ-007 count  input  ADDR_W+1  number of words to dump (0 legal); captured on accepted start.
REQ-008 busy  output  1  high from the cycle after accepted start until done.
REQ-009 done  output  1  one-cycle pulse at dump completion.
REQ-010 mem_re  output  1  read strobe to data-memory read port.
REQ-011 mem_addr  output  ADDR_W  word address for mem_re.
REQ-012 mem_rdata  input  DATA_W  read data, valid exactly one cycle after mem_re.
REQ-013 out_valid  output  1  stream beat valid.
REQ-014 out_ready  input  1  sink accepts beat when high with out_valid.
REQ-015 out_data  output  DATA_W  stream payload.
REQ-016 out_last  output  1  marks final beat of the dump.

Function
REQ-017 FSM states SHALL be IDLE, READ, WAIT, SEND, CSUM, FIN.
- IDLE -> READ on start with count>0; IDLE -> FIN (or CSUM, see REQ-030) on start with count==0.
- READ: mem_re=1 one cycle at current address -> WAIT.
- WAIT: capture mem_rdata into output register -> SEND.
- SEND: out_valid=1; on out_valid&&out_ready, remaining count decrements and address increments; -> READ if words remain, else FIN (or CSUM).
- FIN: done=1 one cycle -> IDLE.
REQ-018 Latency SHALL be: start at cycle 0, mem_re at cycle 1, out_valid at cycle 3 for the first word; three cycles per word with out_ready held high.
REQ-019 out_data and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 out_valid SHALL never drop without a completed handshake, except on reset.
REQ-021 Address SHALL increment modulo 2^ADDR_W (255 -> 0 for ADDR_W=8).
REQ-022 start SHALL be ignored while busy; no state change occurs.
REQ-023 With count==0 and no checksum, no beat is emitted and done pulses 2 cycles after start.
REQ-024 out_last SHALL be 1 only on the final beat of the dump.
REQ-025 mem_re SHALL be 0 outside READ; no memory writes are issued.

Reset
REQ-026 On reset low, the FSM SHALL go to IDLE immediately, regardless of clock.
REQ-027 Reset values SHALL be: busy=0, done=0, mem_re=0, mem_addr=0, out_valid=0, out_data=0, out_last=0, checksum=0.
REQ-028 Reset mid-dump SHALL abandon the dump with no done pulse; the next start begins a fresh dump.

Configuration
REQ-029 Macro MEM_DUMP_CHECKSUM_EN SHALL compile the checksum feature in or out.
REQ-030 When defined: DATA_W-bit wrapping sum of all sent words, emitted in CSUM as one extra beat after the data beats, carrying out_last=1, with the same handshake; count==0 emits a single beat of value 0. When undefined: CSUM state and accumulator absent; the last data beat carries out_last.

Structure
REQ-031 DATA_W default and the FSM state enum SHALL live in the shared package mips_pkg.
REQ-032 No sub-module is required; the checksum accumulator is inline, under the macro.

Verification
REQ-033 Fibonacci image mem[0..9]=0,1,1,2,3,5,8,13,21,34; base 0, count 10, ready=1 -> 10 beats in order, last on beat 10, done one cycle after, first valid at cycle 3.
REQ-034 Same image with MEM_DUMP_CHECKSUM_EN -> 11 beats, beat 11 = 88 with last=1, beat 10 last=0.
REQ-035 Backpressure: ready low 3 cycles while beat 4 (value 2) is valid -> data/last held stable, no beat lost or duplicated.
REQ-036 Wrap: ADDR_W=8, base 254, count 4 -> mem_addr sequence 254, 255, 0, 1.
REQ-037 count 0 without macro -> no out_valid, done pulse 2 cycles after start; start during busy ignored.
REQ-038 Reset asserted while beat 5 is valid -> all outputs reset immediately, no done pulse; a new start with count 2 dumps mem[0..1] correctly.
